serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B, one bit per clock, LSB first.
// Operands are captured on Start; results are held until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             V
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] sr_reg;
    logic             br_reg;
    logic [CW-1:0]    cnt_reg;
    logic             a_s_reg;
    logic             b_s_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             v_reg;

    logic             accept;
    logic             last_step;
    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             br_next;
    logic [WIDTH-1:0] sr_next;

    // One full-subtractor cell, reused every bit step.
    assign bit_a     = sa_reg[0];
    assign bit_b     = sb_reg[0];
    assign bit_d     = bit_a ^ bit_b ^ br_reg;
    assign br_next   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_reg);
    assign sr_next   = {bit_d, sr_reg[WIDTH-1:1]};
    assign last_step = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                // Start in the done cycle is accepted back-to-back.
                if (Start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            sr_reg    <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            a_s_reg   <= 1'b0;
            b_s_reg   <= 1'b0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            v_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                sa_reg  <= A;
                sb_reg  <= B;
                br_reg  <= 1'b0;
                cnt_reg <= '0;
                a_s_reg <= A[WIDTH-1];
                b_s_reg <= B[WIDTH-1];
            end else if (state_reg == RUN) begin
                sa_reg  <= {1'b0, sa_reg[WIDTH-1:1]};
                sb_reg  <= {1'b0, sb_reg[WIDTH-1:1]};
                sr_reg  <= sr_next;
                br_reg  <= br_next;
                cnt_reg <= cnt_reg + CW'(1);
                // The last bit computed is the result MSB, so V uses bit_d directly.
                if (last_step) begin
                    diff_reg <= sr_next;
                    bout_reg <= br_next;
                    v_reg    <= (a_s_reg ^ b_s_reg) & (a_s_reg ^ bit_d);
                end
            end
        end
    end

    assign Busy = (state_reg == RUN);
    assign Done = (state_reg == FIN);
    assign Diff = diff_reg;
    assign Bout = bout_reg;
    assign V    = v_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed literal cases plus a randomized
// run compared every cycle against an arithmetic reference model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         V;

    always #5 CLK = ~CLK;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .Start(Start),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .Done (Done),
        .Diff (Diff),
        .Bout (Bout),
        .V    (V)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain modular and signed integer arithmetic.
    function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] d, output logic bo, output logic v);
        int sa;
        int sb;
        int sd;
        sa = $signed(a);
        sb = $signed(b);
        sd = sa - sb;
        d  = a - b;
        bo = (a < b);
        v  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    endfunction

    // Cycle-level model: an op accepted at edge k is busy through edge k+W-1 and done at k+W.
    int           cyc = 0;
    int           done_cyc = -1;
    bit           accept_m;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_bout = 1'b0;
    logic         m_v = 1'b0;
    logic [W-1:0] p_diff, p_a, p_b, m_a, m_b;
    logic         p_bout, p_v;

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_diff   = '0;
            m_bout   = 1'b0;
            m_v      = 1'b0;
            done_cyc = -1;
        end else begin
            accept_m = Start && !m_busy;
            m_done   = (cyc == done_cyc);
            if (m_done) begin
                m_busy = 1'b0;
                m_diff = p_diff;
                m_bout = p_bout;
                m_v    = p_v;
                m_a    = p_a;
                m_b    = p_b;
            end
            if (accept_m) begin
                p_a = A;
                p_b = B;
                ref_sub(A, B, p_diff, p_bout, p_v);
                done_cyc = cyc + W;
                m_busy   = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            chk("busy", 32'(Busy), 32'(m_busy));
            chk("done", 32'(Done), 32'(m_done));
            chk("diff", 32'(Diff), 32'(m_diff));
            chk("bout", 32'(Bout), 32'(m_bout));
            chk("v",    32'(V),    32'(m_v));
            if (m_done)
                $display("op A=0x%02h B=0x%02h -> Diff=0x%02h Bout=%0d V=%0d", m_a, m_b, Diff, Bout, V);
        end
    end

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (Done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Called just after an edge with the DUT idle; returns just after an edge, idle again.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic eb, input logic ev);
        int lat;
        A = a;
        B = b;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        chk({name, "_busy"}, 32'(Busy), 32'd1);
        wait_done(lat);
        chk({name, "_latency"}, 32'(lat), 32'(W));
        chk({name, "_diff"}, 32'(Diff), 32'(ed));
        chk({name, "_bout"}, 32'(Bout), 32'(eb));
        chk({name, "_v"}, 32'(V), 32'(ev));
        @(posedge CLK);
        #1;
    endtask

    logic [W-1:0] sp [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

    initial begin
        logic [W-1:0] rd;
        logic         rb, rv;
        int           lat;
        int           n_done;
        logic [W-1:0] seen_diff;

        ref_sub(8'd100, 8'd37, rd, rb, rv);
        chk("model_100_37", {23'd0, rd, rb, rv}, {23'd0, 8'h3F, 1'b0, 1'b0});
        ref_sub(8'h80, 8'h01, rd, rb, rv);
        chk("model_80_01", {23'd0, rd, rb, rv}, {23'd0, 8'h7F, 1'b0, 1'b1});
        ref_sub(8'h7F, 8'hFF, rd, rb, rv);
        chk("model_7F_FF", {23'd0, rd, rb, rv}, {23'd0, 8'h80, 1'b1, 1'b1});

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_en = 1'b1;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_diff", 32'(Diff), 32'd0);
        chk("reset_bout", 32'(Bout), 32'd0);
        chk("reset_v",    32'(V),    32'd0);

        do_op("d100_37", 8'd100, 8'd37, 8'h3F, 1'b0, 1'b0);
        do_op("d05_0A",  8'h05, 8'h0A, 8'hFB, 1'b1, 1'b0);
        do_op("d80_01",  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        do_op("d7F_FF",  8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        do_op("d3C_3C",  8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0);

        // Start while busy must be ignored.
        A = 8'h50;
        B = 8'h10;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        A = 8'h01;
        B = 8'h02;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        n_done = 0;
        seen_diff = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (Done === 1'b1) begin
                n_done++;
                seen_diff = Diff;
            end
        end
        chk("ignored_start_dones", 32'(n_done), 32'd1);
        chk("ignored_start_diff", 32'(seen_diff), 32'h40);
        @(posedge CLK);
        #1;

        // Back-to-back Start in the done cycle.
        A = 8'h05;
        B = 8'h0A;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        wait_done(lat);
        chk("b2b_first_diff", 32'(Diff), 32'hFB);
        A = 8'h10;
        B = 8'h20;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        chk("b2b_busy", 32'(Busy), 32'd1);
        wait_done(lat);
        chk("b2b_latency", 32'(lat), 32'(W));
        chk("b2b_diff", 32'(Diff), 32'hF0);
        chk("b2b_bout", 32'(Bout), 32'd1);
        chk("b2b_v", 32'(V), 32'd0);
        @(posedge CLK);
        #1;

        // Reset in the middle of an operation.
        A = 8'h33;
        B = 8'h11;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_done", 32'(Done), 32'd0);
        chk("midrst_diff", 32'(Diff), 32'd0);
        chk("midrst_bout", 32'(Bout), 32'd0);
        chk("midrst_v",    32'(V),    32'd0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (Done === 1'b1) n_done++;
        end
        chk("midrst_no_done", 32'(n_done), 32'd0);
        @(posedge CLK);
        #1;
        do_op("after_rst", 8'd9, 8'd4, 8'd5, 1'b0, 1'b0);

        // Randomized traffic: ignored starts, back-to-back ops, corner operands, rare resets.
        for (int i = 0; i < 12000; i++) begin
            Start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0: begin
                    A = sp[$urandom_range(0, 3)];
                    B = sp[$urandom_range(0, 3)];
                end
                1: begin
                    A = W'($urandom);
                    B = A;
                end
                default: begin
                    A = W'($urandom);
                    B = W'($urandom);
                end
            endcase
            RST = ($urandom_range(0, 999) == 0);
            @(posedge CLK);
            #1;
        end
        Start = 1'b0;
        RST = 1'b0;
        repeat (12) @(posedge CLK);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
